// File: rtl/tv_out_packer.sv
// tv_out_packer: packs DATA_WIDTH_OUT task words into little-endian 32-bit beats for readback.
// Define TV_OUT_CHECKSUM_EN to append an XOR-of-all-data-beats checksum beat as the last beat.
module tv_out_packer #(
    parameter int DATA_WIDTH_OUT = 16,
    parameter int NUM_WORDS_OUT = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH_OUT-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [31:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);
    localparam int W = DATA_WIDTH_OUT;
    localparam int N = NUM_WORDS_OUT;
    localparam int TV_OUT_NUM_TRANSACTIONS = (N * W + 31) / 32;
`ifdef TV_OUT_CHECKSUM_EN
    localparam int NB = TV_OUT_NUM_TRANSACTIONS + 1;
`else
    localparam int NB = TV_OUT_NUM_TRANSACTIONS;
`endif
    // A 64-bit word fills a double-width accumulator that drains as two beats.
    localparam int AW = W > 32 ? W : 32;
    localparam int WPA = AW / W;
    localparam int BPA = AW / 32;
    localparam int LW = WPA > 1 ? $clog2(WPA) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int BW = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state, state_nx;

    logic [CW-1:0] word_cnt;
    logic [BW-1:0] beat_cnt;
    logic [AW-1:0] acc;
    logic [LW-1:0] lane;
    logic          sub;
    logic          acc_full;
    logic          accept;
    logic          drain_ok;
    logic          mv_data;
    logic          mv_ck;
    logic [31:0]   chunk;
`ifdef TV_OUT_CHECKSUM_EN
    logic [BW-1:0] mv_cnt;
    logic [31:0]   xr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: state_nx = start ? RUN : IDLE;
            RUN: begin
                busy = 1'b1;
                in_ready = !acc_full && word_cnt < CW'(N);
                state_nx = word_cnt == CW'(N) ? DRAIN : RUN;
            end
            DRAIN: begin
                busy = 1'b1;
                state_nx = (out_valid && out_ready && beat_cnt == BW'(NB - 1)) ? FIN : DRAIN;
            end
            FIN: begin
                done = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    assign out_last = out_valid && beat_cnt == BW'(NB - 1);
    assign accept   = in_valid && in_ready;
    assign drain_ok = !out_valid || out_ready;
    assign mv_data  = acc_full && drain_ok;
    assign chunk    = (BPA == 2 && sub) ? acc[AW-1 -: 32] : acc[31:0];
`ifdef TV_OUT_CHECKSUM_EN
    assign mv_ck = state == DRAIN && !acc_full && mv_cnt == BW'(TV_OUT_NUM_TRANSACTIONS) && drain_ok;
`else
    assign mv_ck = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt  <= '0;
            beat_cnt  <= '0;
            acc       <= '0;
            lane      <= '0;
            sub       <= 1'b0;
            acc_full  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef TV_OUT_CHECKSUM_EN
            mv_cnt    <= '0;
            xr        <= '0;
`endif
        end else if (state == IDLE) begin
            if (start) begin
                word_cnt  <= '0;
                beat_cnt  <= '0;
                acc       <= '0;
                lane      <= '0;
                sub       <= 1'b0;
                acc_full  <= 1'b0;
                out_valid <= 1'b0;
`ifdef TV_OUT_CHECKSUM_EN
                mv_cnt    <= '0;
                xr        <= '0;
`endif
            end
        end else begin
            // accept needs an empty acc and a move needs a full one, so they never coincide
            if (accept) begin
                acc[lane*W +: W] <= in_data;
                lane     <= lane == LW'(WPA - 1) ? '0 : lane + 1'b1;
                word_cnt <= word_cnt + 1'b1;
                acc_full <= lane == LW'(WPA - 1) || word_cnt == CW'(N - 1);
            end
            if (mv_data) begin
                out_data <= chunk;
`ifdef TV_OUT_CHECKSUM_EN
                xr     <= xr ^ chunk;
                mv_cnt <= mv_cnt + 1'b1;
`endif
                if (sub == 1'(BPA - 1)) begin
                    acc      <= '0;
                    acc_full <= 1'b0;
                    sub      <= 1'b0;
                end else begin
                    sub <= 1'b1;
                end
            end
`ifdef TV_OUT_CHECKSUM_EN
            else if (mv_ck) begin
                out_data <= xr;
                mv_cnt   <= mv_cnt + 1'b1;
            end
`endif
            out_valid <= (mv_data || mv_ck) ? 1'b1 : (out_ready ? 1'b0 : out_valid);
            if (out_valid && out_ready) beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_tv_out_packer.sv
// tb_tv_out_packer: scoreboard bench over 8-, 16- and 64-bit packer instances.
module tb_tv_out_packer;
`ifdef TV_OUT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s8 = 0, iv8 = 0, ir8, ov8, ordy8 = 1, ol8, b8, d8;
    logic [7:0] id8 = 0;
    logic [31:0] od8;
    logic s16 = 0, iv16 = 0, ir16, ov16, ordy16 = 1, ol16, b16, d16;
    logic [15:0] id16 = 0;
    logic [31:0] od16;
    logic s64 = 0, iv64 = 0, ir64, ov64, ordy64 = 1, ol64, b64, d64;
    logic [63:0] id64 = 0;
    logic [31:0] od64;
    logic [32:0] q8[$], q16[$], q64[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    tv_out_packer #(.DATA_WIDTH_OUT(8), .NUM_WORDS_OUT(8)) u8 (
        .clk(clk), .rst(rst), .start(s8), .in_data(id8), .in_valid(iv8), .in_ready(ir8),
        .out_data(od8), .out_valid(ov8), .out_ready(ordy8), .out_last(ol8), .busy(b8), .done(d8));
    tv_out_packer #(.DATA_WIDTH_OUT(16), .NUM_WORDS_OUT(3)) u16 (
        .clk(clk), .rst(rst), .start(s16), .in_data(id16), .in_valid(iv16), .in_ready(ir16),
        .out_data(od16), .out_valid(ov16), .out_ready(ordy16), .out_last(ol16), .busy(b16), .done(d16));
    tv_out_packer #(.DATA_WIDTH_OUT(64), .NUM_WORDS_OUT(1)) u64 (
        .clk(clk), .rst(rst), .start(s64), .in_data(id64), .in_valid(iv64), .in_ready(ir64),
        .out_data(od64), .out_valid(ov64), .out_ready(ordy64), .out_last(ol64), .busy(b64), .done(d64));

    task automatic test_reset;
        rst = 1'b1;
        iv8 = 1; iv16 = 1; iv64 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ov8, ol8, od8, ir8, b8, d8} !== 38'h0) begin
            errors++; $display("FAIL reset_u8: got %h expected 0", {ov8, ol8, od8, ir8, b8, d8});
        end
        checks++;
        if ({ov16, ol16, od16, ir16, b16, d16} !== 38'h0) begin
            errors++; $display("FAIL reset_u16: got %h expected 0", {ov16, ol16, od16, ir16, b16, d16});
        end
        checks++;
        if ({ov64, ol64, od64, ir64, b64, d64} !== 38'h0) begin
            errors++; $display("FAIL reset_u64: got %h expected 0", {ov64, ol64, od64, ir64, b64, d64});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ir8, ir16, ir64} !== 3'b000) begin
            errors++; $display("FAIL idle_in_ready: got %b expected 000", {ir8, ir16, ir64});
        end
        iv8 = 0; iv16 = 0; iv64 = 0;
    endtask

    task automatic test_w8(input int stall_len);
        int ni = 0, lane = 0, left = 0, seen = 0;
        bit started = 0, fin = 0, got_last = 0, hv = 0, took;
        logic [31:0] mb = 0, xr = 0;
        logic [32:0] held, e;
        q8.delete();
        @(posedge clk); #1;
        s8 = 1; iv8 = 1; id8 = 8'd1; ordy8 = 1;
        @(posedge clk); #1;
        s8 = 0;
        checks++;
        if (b8 !== 1'b1) begin errors++; $display("FAIL w8_busy: got %b expected 1", b8); end
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            took = iv8 && ir8;
            if (got_last) begin
                checks++;
                if ({d8, b8} !== 2'b10) begin
                    errors++; $display("FAIL w8_done: got done,busy=%b expected 10", {d8, b8});
                end
                fin = 1;
            end else begin
                if (took) begin
                    mb[lane*8 +: 8] = id8; lane++; ni++;
                    if (lane == 4 || ni == 8) begin
                        xr ^= mb; q8.push_back({!CK && ni == 8, mb}); mb = 0; lane = 0;
                    end
                    if (CK && ni == 8) q8.push_back({1'b1, xr});
                end
                if (ov8 && ordy8) begin
                    checks++;
                    if (q8.size() == 0) begin
                        errors++; $display("FAIL w8_beat: got %h expected no beat", {ol8, od8});
                    end else begin
                        e = q8.pop_front();
                        if ({ol8, od8} !== e) begin
                            errors++; $display("FAIL w8_beat: got %h expected %h", {ol8, od8}, e);
                        end
                        got_last = e[32];
                    end
                end
                if (ov8 && !ordy8) begin
                    seen++;
                    if (hv) begin
                        checks++;
                        if ({ol8, od8} !== held) begin
                            errors++; $display("FAIL w8_hold: got %h expected %h", {ol8, od8}, held);
                        end
                    end
                    hv = 1; held = {ol8, od8};
                    if (seen == 5) begin
                        checks++;
                        if (ir8 !== 1'b0) begin errors++; $display("FAIL w8_in_ready_full: got %b expected 0", ir8); end
                    end
                end else hv = 0;
            end
            @(posedge clk); #1;
            iv8 = ni < 8;
            id8 = 8'(ni + 1);
            if (stall_len > 0 && ov8 && !started) begin started = 1; left = stall_len; end
            ordy8 = left == 0;
            if (left > 0) left--;
        end
        iv8 = 0; ordy8 = 1;
        checks++;
        if (!fin || q8.size() != 0) begin
            errors++; $display("FAIL w8_complete: got fin=%0d left=%0d expected fin=1 left=0", fin, q8.size());
        end
    endtask

    task automatic test_reset_mid_run;
        int ni = 0;
        @(posedge clk); #1;
        s8 = 1; iv8 = 1; id8 = 8'd1; ordy8 = 1;
        @(posedge clk); #1;
        s8 = 0;
        for (int c = 0; c < 20 && ni < 3; c++) begin
            @(negedge clk);
            if (iv8 && ir8) ni++;
            @(posedge clk); #1;
            id8 = 8'(ni + 1);
        end
        iv8 = 0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({ov8, ol8, od8, ir8, b8, d8} !== 38'h0) begin
            errors++; $display("FAIL mid_reset: got %h expected 0", {ov8, ol8, od8, ir8, b8, d8});
        end
        rst = 1'b0;
        test_w8(0);
    endtask

    task automatic test_w16_pad;
        int ni = 0, lane = 0;
        bit fin = 0, got_last = 0, took;
        logic [31:0] mb = 0, xr = 0;
        logic [32:0] e;
        q16.delete();
        @(posedge clk); #1;
        s16 = 1; iv16 = 1; id16 = 16'd1;
        @(posedge clk); #1;
        s16 = 0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            @(negedge clk);
            took = iv16 && ir16;
            if (got_last) begin
                checks++;
                if ({d16, b16} !== 2'b10) begin
                    errors++; $display("FAIL w16_done: got done,busy=%b expected 10", {d16, b16});
                end
                fin = 1;
            end else begin
                if (took) begin
                    mb[lane*16 +: 16] = id16; lane++; ni++;
                    if (lane == 2 || ni == 3) begin
                        xr ^= mb; q16.push_back({!CK && ni == 3, mb}); mb = 0; lane = 0;
                    end
                    if (CK && ni == 3) q16.push_back({1'b1, xr});
                end
                if (ov16 && ordy16) begin
                    checks++;
                    if (q16.size() == 0) begin
                        errors++; $display("FAIL w16_beat: got %h expected no beat", {ol16, od16});
                    end else begin
                        e = q16.pop_front();
                        if ({ol16, od16} !== e) begin
                            errors++; $display("FAIL w16_beat: got %h expected %h", {ol16, od16}, e);
                        end
                        got_last = e[32];
                    end
                end
            end
            @(posedge clk); #1;
            iv16 = ni < 3;
            id16 = 16'(ni + 1);
        end
        iv16 = 0;
        checks++;
        if (!fin || q16.size() != 0) begin
            errors++; $display("FAIL w16_complete: got fin=%0d left=%0d expected fin=1 left=0", fin, q16.size());
        end
    endtask

    task automatic test_w64_split;
        int ni = 0;
        bit fin = 0, got_last = 0;
        logic [32:0] e;
        q64.delete();
        @(posedge clk); #1;
        s64 = 1; iv64 = 1; id64 = 64'h1122334455667788;
        @(posedge clk); #1;
        s64 = 0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            @(negedge clk);
            if (got_last) begin
                checks++;
                if ({d64, b64} !== 2'b10) begin
                    errors++; $display("FAIL w64_done: got done,busy=%b expected 10", {d64, b64});
                end
                fin = 1;
            end else begin
                if (iv64 && ir64) begin
                    ni++;
                    q64.push_back({1'b0, id64[31:0]});
                    q64.push_back({!CK, id64[63:32]});
                    if (CK) q64.push_back({1'b1, id64[31:0] ^ id64[63:32]});
                end
                if (ov64 && ordy64) begin
                    checks++;
                    if (q64.size() == 0) begin
                        errors++; $display("FAIL w64_beat: got %h expected no beat", {ol64, od64});
                    end else begin
                        e = q64.pop_front();
                        if ({ol64, od64} !== e) begin
                            errors++; $display("FAIL w64_beat: got %h expected %h", {ol64, od64}, e);
                        end
                        got_last = e[32];
                    end
                end
            end
            @(posedge clk); #1;
            iv64 = ni < 1;
        end
        iv64 = 0;
        checks++;
        if (!fin || q64.size() != 0) begin
            errors++; $display("FAIL w64_complete: got fin=%0d left=%0d expected fin=1 left=0", fin, q64.size());
        end
    endtask

    initial begin
        test_reset;
        test_w8(0);
        test_w8(5);
        test_reset_mid_run;
        test_w16_pad;
        test_w64_split;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
